// File: rtl/seq_pkg.sv
// Shared types and widths for the codec sample sequencer.
package seq_pkg;

   localparam int SEQ_DATA_W = 24;
   localparam int SEQ_CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      PROC    = 3'd2,
      WAIT_WR = 3'd3,
      WRITE   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/codec_sample_sequencer_if.sv
// Codec FIFO and filter-side signals of the sample sequencer, bundled as one interface.
// master = the sequencer, slave = the codec/filter environment.
interface codec_sample_sequencer_if
   import seq_pkg::*;
#(
   parameter int DATA_W = SEQ_DATA_W
);

   logic              read_ready;
   logic              write_ready;
   logic [DATA_W-1:0] readdata_left;
   logic [DATA_W-1:0] readdata_right;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata_left;
   logic [DATA_W-1:0] writedata_right;
   logic [DATA_W-1:0] smp_left;
   logic [DATA_W-1:0] smp_right;
   logic              smp_valid;
   logic [DATA_W-1:0] proc_left;
   logic [DATA_W-1:0] proc_right;
   logic              proc_valid;
   logic              mute;
   logic              overrun;

   modport master (
      input  read_ready, write_ready, readdata_left, readdata_right,
      input  proc_left, proc_right, proc_valid, mute,
      output read, write, writedata_left, writedata_right,
      output smp_left, smp_right, smp_valid, overrun
   );

   modport slave (
      output read_ready, write_ready, readdata_left, readdata_right,
      output proc_left, proc_right, proc_valid, mute,
      input  read, write, writedata_left, writedata_right,
      input  smp_left, smp_right, smp_valid, overrun
   );

endinterface

// File: rtl/seq_watchdog.sv
// PROC-residency counter: cleared on a new sample, counts while enabled, flags
// the last permitted cycle so the sequencer can bypass the filters.
module seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int               CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: clear wins over enable; the counter never passes LAST because
   // the sequencer leaves PROC on the expiry cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/codec_sample_sequencer.sv
// Codec sample sequencer: pops a stereo sample, hands it to the filters, and
// pushes the filtered (or watchdog-bypassed raw) result back to the codec DAC.
// Optional macro SEQ_OVERRUN_CNT_EN adds a saturating 16-bit overrun_count output.
module codec_sample_sequencer
   import seq_pkg::*;
#(
   parameter int DATA_W         = SEQ_DATA_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   codec_sample_sequencer_if.master     bus
`ifdef SEQ_OVERRUN_CNT_EN
   ,
   output logic [SEQ_CNT_W-1:0]         overrun_count
`endif
);

   seq_state_t        state_d,     state_q;
   logic              read_d,      read_q;
   logic              write_d,     write_q;
   logic              smp_valid_d, smp_valid_q;
   logic              overrun_d,   overrun_q;
   logic [DATA_W-1:0] smp_l_d,     smp_l_q;
   logic [DATA_W-1:0] smp_r_d,     smp_r_q;
   logic [DATA_W-1:0] wd_l_d,      wd_l_q;
   logic [DATA_W-1:0] wd_r_d,      wd_r_q;

   logic wdog_clear;
   logic wdog_enable;
   logic wdog_expired;

   assign wdog_clear  = (state_q == READ);
   assign wdog_enable = (state_q == PROC);

   seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wdog_clear),
      .enable  (wdog_enable),
      .expired (wdog_expired)
   );

   // Next-state and next-output logic; strobes are computed one state ahead so
   // that every output comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      read_d      = 1'b0;
      write_d     = 1'b0;
      smp_valid_d = 1'b0;
      overrun_d   = 1'b0;
      smp_l_d     = smp_l_q;
      smp_r_d     = smp_r_q;
      wd_l_d      = wd_l_q;
      wd_r_d      = wd_r_q;

      case (state_q)
         IDLE: begin
            if (bus.read_ready) begin
               state_d = READ;
               read_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         READ: begin
            smp_l_d     = bus.readdata_left;
            smp_r_d     = bus.readdata_right;
            smp_valid_d = 1'b1;
            state_d     = PROC;
         end

         // Filter result beats the watchdog when both land on the same cycle.
         PROC: begin
            if (bus.proc_valid) begin
               wd_l_d  = bus.mute ? '0 : bus.proc_left;
               wd_r_d  = bus.mute ? '0 : bus.proc_right;
               state_d = WAIT_WR;
            end else if (wdog_expired) begin
               wd_l_d    = bus.mute ? '0 : smp_l_q;
               wd_r_d    = bus.mute ? '0 : smp_r_q;
               overrun_d = 1'b1;
               state_d   = WAIT_WR;
            end else begin
               state_d = PROC;
            end
         end

         WAIT_WR: begin
            if (bus.write_ready) begin
               state_d = WRITE;
               write_d = 1'b1;
            end else begin
               state_d = WAIT_WR;
            end
         end

         WRITE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer FSM, capture and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         smp_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         smp_l_q     <= '0;
         smp_r_q     <= '0;
         wd_l_q      <= '0;
         wd_r_q      <= '0;
      end else begin
         state_q     <= state_d;
         read_q      <= read_d;
         write_q     <= write_d;
         smp_valid_q <= smp_valid_d;
         overrun_q   <= overrun_d;
         smp_l_q     <= smp_l_d;
         smp_r_q     <= smp_r_d;
         wd_l_q      <= wd_l_d;
         wd_r_q      <= wd_r_d;
      end
   end

   assign bus.read            = read_q;
   assign bus.write           = write_q;
   assign bus.smp_valid       = smp_valid_q;
   assign bus.overrun         = overrun_q;
   assign bus.smp_left        = smp_l_q;
   assign bus.smp_right       = smp_r_q;
   assign bus.writedata_left  = wd_l_q;
   assign bus.writedata_right = wd_r_q;

`ifdef SEQ_OVERRUN_CNT_EN
   logic [SEQ_CNT_W-1:0] ovr_cnt_d;
   logic [SEQ_CNT_W-1:0] ovr_cnt_q;

   // Saturating tally of watchdog bypasses.
   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_q && (ovr_cnt_q != {SEQ_CNT_W{1'b1}})) begin
         ovr_cnt_d = ovr_cnt_q + SEQ_CNT_W'(1);
      end else begin
         ovr_cnt_d = ovr_cnt_q;
      end
   end

   // Overrun counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_codec_sample_sequencer.sv
// Randomized self-checking bench for codec_sample_sequencer against a
// transaction-level model of one pop/process/push loop.
module tb_codec_sample_sequencer;
   import seq_pkg::*;

   localparam int DW = 24;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   codec_sample_sequencer_if #(.DATA_W(DW)) bus ();

`ifdef SEQ_OVERRUN_CNT_EN
   logic [SEQ_CNT_W-1:0] ovr_cnt;
`endif

   codec_sample_sequencer #(
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef SEQ_OVERRUN_CNT_EN
      ,
      .overrun_count (ovr_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] held_l;
   logic [DW-1:0] held_r;
   int            ovr_model;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_quiet();
      bus.read_ready     = 1'b0;
      bus.write_ready    = 1'b0;
      bus.readdata_left  = '0;
      bus.readdata_right = '0;
      bus.proc_left      = '0;
      bus.proc_right     = '0;
      bus.proc_valid     = 1'b0;
      bus.mute           = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_strobes"}, 32'({bus.read, bus.write, bus.smp_valid, bus.overrun}), 32'(4'b0000));
      check_val({tag, "_smp"}, 32'({bus.smp_left, bus.smp_right} != 48'd0), 32'(1'b0));
      check_val({tag, "_wd"}, 32'({bus.writedata_left, bus.writedata_right} != 48'd0), 32'(1'b0));
   endtask

   // One sample loop. d = index of the PROC cycle carrying proc_valid (>= TO means
   // the filters never answer in time), w = WAIT_WR cycles with write_ready low,
   // mmode 0 = no mute, 1 = mute at load, 2 = mute everywhere except the load cycle.
   task automatic run_txn(input logic [DW-1:0] rl, input logic [DW-1:0] rr,
                          input logic [DW-1:0] pl, input logic [DW-1:0] pr,
                          input int d, input int w, input int g, input int mmode,
                          input bit hold, input bit spur, input int rst_at);
      bit            ovr;
      int            lp;
      int            e;
      logic [DW-1:0] el;
      logic [DW-1:0] er;

      ovr = (d >= TO);
      lp  = ovr ? TO : d + 1;
      e   = lp + 3 + w;
      el  = (mmode == 1) ? '0 : (ovr ? rl : pl);
      er  = (mmode == 1) ? '0 : (ovr ? rr : pr);

      bus.read_ready = 1'b0;
      repeat (g) begin
         @(negedge clk);
         check_val("idle_strobes", 32'({bus.read, bus.write, bus.smp_valid, bus.overrun}), 32'(4'b0000));
         check_val("idle_hold_l", 32'(bus.writedata_left), 32'(held_l));
         check_val("idle_hold_r", 32'(bus.writedata_right), 32'(held_r));
`ifdef SEQ_OVERRUN_CNT_EN
         check_val("ovr_count", 32'(ovr_cnt), 32'(ovr_model));
`endif
      end

      for (int c = 0; c <= e; c++) begin
         if (c > 0) begin
            @(negedge clk);
            check_val("strobes", 32'({bus.read, bus.write, bus.smp_valid, bus.overrun}),
                      32'({c == 1, c == e, c == 2, ovr && (c == lp + 2)}));
            if (c >= 2) begin
               check_val("smp_l", 32'(bus.smp_left), 32'(rl));
               check_val("smp_r", 32'(bus.smp_right), 32'(rr));
            end
            if (c >= lp + 2) begin
               check_val("wd_l", 32'(bus.writedata_left), 32'(el));
               check_val("wd_r", 32'(bus.writedata_right), 32'(er));
            end else begin
               check_val("wd_hold_l", 32'(bus.writedata_left), 32'(held_l));
               check_val("wd_hold_r", 32'(bus.writedata_right), 32'(held_r));
            end
         end

         if (rst_at > 0 && c == rst_at) begin
            drive_quiet();
            reset = 1'b1;
            #1;
            check_all_zero("midrst");
            @(negedge clk);
            check_all_zero("midrst_hold");
            reset     = 1'b0;
            held_l    = '0;
            held_r    = '0;
            ovr_model = 0;
            return;
         end

         bus.read_ready     = (c <= 1) || (hold && c < e);
         bus.readdata_left  = rl;
         bus.readdata_right = rr;
         bus.proc_valid     = (c == 2 + d) || (spur && c <= 1);
         bus.proc_left      = (c == 2 + d) ? pl : DW'($urandom);
         bus.proc_right     = (c == 2 + d) ? pr : DW'($urandom);
         bus.write_ready    = (c < e) && ((w == 0) || (c >= lp + 2 + w));
         bus.mute           = (mmode == 1) ? (c <= lp + 1) :
                              (mmode == 2) ? (c != lp + 1) : 1'b0;
      end

      held_l = el;
      held_r = er;
      if (ovr && ovr_model < 65535) begin
         ovr_model++;
      end
   endtask

   initial begin
      int r;
      drive_quiet();
      reset     = 1'b1;
      held_l    = '0;
      held_r    = '0;
      ovr_model = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
`ifdef SEQ_OVERRUN_CNT_EN
      check_val("reset_ovr_count", 32'(ovr_cnt), 32'd0);
`endif
      reset = 1'b0;

      // Basic loop: filters answer one cycle after smp_valid.
      run_txn(24'h123456, 24'hABCDEF, 24'h000111, 24'h000222, 1, 0, 1, 0, 1'b0, 1'b0, 0);
      // Timeout bypass: filters never answer.
      run_txn(24'h800001, 24'h7FFFFE, 24'h0A0A0A, 24'h0B0B0B, 20, 0, 2, 0, 1'b0, 1'b0, 0);
      // proc_valid exactly on the expiry cycle.
      run_txn(24'h00F00F, 24'hF00F00, 24'h5A5A5A, 24'hA5A5A5, TO - 1, 0, 1, 0, 1'b0, 1'b0, 0);
      // Backpressure with read_ready held high.
      run_txn(24'h111111, 24'h222222, 24'h333333, 24'h444444, 0, 20, 1, 0, 1'b1, 1'b0, 0);
      // Mute at the load cycle, then mute everywhere except the load cycle.
      run_txn(24'h765432, 24'h234567, 24'h0F0F0F, 24'hF0F0F0, 2, 1, 1, 1, 1'b0, 1'b0, 0);
      run_txn(24'h13579B, 24'h2468AC, 24'h0C0C0C, 24'hC0C0C0, 3, 0, 1, 2, 1'b0, 1'b1, 0);
      // Reset during WAIT_WR, then a normal loop restarts from IDLE.
      run_txn(24'hDEAD01, 24'hBEEF02, 24'h0CAFE0, 24'h0FACE0, 0, 5, 1, 0, 1'b0, 1'b0, 4);
      run_txn(24'h0000FF, 24'hFF0000, 24'h00AA00, 24'h0000BB, 0, 0, 2, 0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 5));
         run_txn(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                 int'($urandom_range(0, 9)), int'($urandom_range(0, 4)),
                 int'($urandom_range(1, 3)), (r == 4) ? 1 : ((r == 5) ? 2 : 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      // Final idle check so the last transaction's held values and count are seen.
      run_txn(24'h000001, 24'h000002, 24'h000003, 24'h000004, TO, 0, 2, 0, 1'b0, 1'b0, 0);
      repeat (2) begin
         @(negedge clk);
         check_val("end_hold_l", 32'(bus.writedata_left), 32'(held_l));
`ifdef SEQ_OVERRUN_CNT_EN
         check_val("end_ovr_count", 32'(ovr_cnt), 32'(ovr_model));
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
